// File: rtl/msrv32_integer_file.sv
// Integer register file x0..x31 with two combinational read ports; x0 reads zero.
// Optional write-through bypass on the read ports: define MSRV32_INTEGER_FILE_BYPASS_EN.

module msrv32_integer_file_rd_port #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic [NUM_REGS-1:0][XLEN-1:0] file_view,
  input  logic [ADDR_W-1:0]             addr,
  input  logic                          fwd,
  input  logic [ADDR_W-1:0]             fwd_addr,
  input  logic [XLEN-1:0]               fwd_data,
  output logic [XLEN-1:0]               data
);
  always_comb begin
    data = file_view[addr];
    if (fwd && (addr == fwd_addr)) data = fwd_data;
  end
endmodule

module msrv32_integer_file #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              ms_riscv32_mp_clk_in,
  input  logic              ms_riscv32_mp_rst_in,
  input  logic [ADDR_W-1:0] rs_1_addr_in,
  input  logic [ADDR_W-1:0] rs_2_addr_in,
  input  logic [ADDR_W-1:0] rd_addr_in,
  input  logic              wr_en_in,
  input  logic [XLEN-1:0]   rd_in,
  output logic [XLEN-1:0]   rs_1_out,
  output logic [XLEN-1:0]   rs_2_out
);
  localparam int NUM_PORTS = 2;

  logic [NUM_REGS-1:1][XLEN-1:0]  regs;
  logic [NUM_REGS-1:0][XLEN-1:0]  file_view;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] port_addr;
  logic [NUM_PORTS-1:0][XLEN-1:0]   port_data;
  logic                             wr_ok;
  logic                             fwd;

  assign wr_ok = wr_en_in && !ms_riscv32_mp_rst_in && (rd_addr_in != '0);

  // Reset wins over a write in the same cycle; x0 has no storage.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) regs <= '0;
    else if (wr_ok)           regs[rd_addr_in] <= rd_in;
  end

  assign file_view = {regs, {XLEN{1'b0}}};

`ifdef MSRV32_INTEGER_FILE_BYPASS_EN
  assign fwd = wr_ok;
`else
  assign fwd = 1'b0;
`endif

  assign port_addr = {rs_2_addr_in, rs_1_addr_in};

  genvar p;
  generate
    for (p = 0; p < NUM_PORTS; p++) begin : g_port
      msrv32_integer_file_rd_port #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)
      ) u_port (
        .file_view (file_view),
        .addr      (port_addr[p]),
        .fwd       (fwd),
        .fwd_addr  (rd_addr_in),
        .fwd_data  (rd_in),
        .data      (port_data[p])
      );
    end
  endgenerate

  assign rs_1_out = port_data[0];
  assign rs_2_out = port_data[1];
endmodule

// File: tb/tb_msrv32_integer_file.sv
// Directed bench for msrv32_integer_file; expectations follow the bypass macro setting.
module tb_msrv32_integer_file;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  rs1_a = '0, rs2_a = '0, rd_a = '0;
  logic        wr = 1'b0;
  logic [31:0] rd_d = '0;
  logic [31:0] rs1_q, rs2_q;
  int errs = 0, checks = 0;

  always #5 clk = ~clk;

  msrv32_integer_file dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .rs_1_addr_in         (rs1_a),
    .rs_2_addr_in         (rs2_a),
    .rd_addr_in           (rd_a),
    .wr_en_in             (wr),
    .rd_in                (rd_d),
    .rs_1_out             (rs1_q),
    .rs_2_out             (rs2_q)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr_reg(input logic [4:0] a, input logic [31:0] d);
    rd_a = a; rd_d = d; wr = 1'b1;
    tick();
    wr = 1'b0;
  endtask

  task automatic rd_both(input string tag, input logic [4:0] a, input logic [31:0] exp);
    rs1_a = a; rs2_a = a; #1;
    chk({tag, "_rs1"}, rs1_q, exp);
    chk({tag, "_rs2"}, rs2_q, exp);
  endtask

  initial begin
    // reset and sweep every address
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) rd_both("reset_sweep", 5'(i), 32'h0);

    // basic write / read on both ports
    wr_reg(5'd5, 32'hDEADBEEF);
    rd_both("wr_x5", 5'd5, 32'hDEADBEEF);

    // write to x0 ignored, neighbours untouched; bypass suppressed on x0
    rd_a = 5'd0; rd_d = 32'hFFFFFFFF; wr = 1'b1; rs1_a = 5'd0; #1;
    chk("x0_same_cycle", rs1_q, 32'h0);
    tick(); wr = 1'b0;
    rd_both("wr_x0", 5'd0, 32'h0);
    rd_both("x0_keeps_x5", 5'd5, 32'hDEADBEEF);
    rd_both("x0_keeps_x1", 5'd1, 32'h0);

    // flushed write has no effect
    wr_reg(5'd7, 32'h11111111);
    rd_a = 5'd7; rd_d = 32'h12345678; wr = 1'b0;
    tick();
    rd_both("flushed_x7", 5'd7, 32'h11111111);

    // different registers on the two ports, one reading rd_addr_in
    wr_reg(5'd31, 32'hCAFEF00D);
    rs1_a = 5'd31; rs2_a = 5'd7; rd_a = 5'd31; #1;
    chk("split_rs1_x31", rs1_q, 32'hCAFEF00D);
    chk("split_rs2_x7", rs2_q, 32'h11111111);

    // reset beats a concurrent write
    wr_reg(5'd10, 32'hA5A5A5A5);
    rd_both("wr_x10", 5'd10, 32'hA5A5A5A5);
    rst = 1'b1; rd_a = 5'd10; rd_d = 32'h1; wr = 1'b1;
    rs1_a = 5'd10; #1;
`ifdef MSRV32_INTEGER_FILE_BYPASS_EN
    chk("bypass_off_in_rst", rs1_q, 32'hA5A5A5A5);
`endif
    tick();
    rst = 1'b0; wr = 1'b0;
    rd_both("rst_x10", 5'd10, 32'h0);
    rd_both("rst_x5", 5'd5, 32'h0);
    rd_both("rst_x31", 5'd31, 32'h0);

    // writes resume right after reset; same-cycle read of the written reg
    wr_reg(5'd3, 32'h7);
    rd_both("wr_x3", 5'd3, 32'h7);
    rs1_a = 5'd3; rs2_a = 5'd5; rd_a = 5'd3; rd_d = 32'h42; wr = 1'b1; #1;
`ifdef MSRV32_INTEGER_FILE_BYPASS_EN
    chk("same_cycle_rs1", rs1_q, 32'h42);
`else
    chk("same_cycle_rs1", rs1_q, 32'h7);
`endif
    chk("same_cycle_rs2_other", rs2_q, 32'h0);
    tick(); wr = 1'b0;
    chk("next_cycle_rs1", rs1_q, 32'h42);

    // back-to-back writes to one register: last wins
    wr_reg(5'd12, 32'h1);
    wr_reg(5'd12, 32'h2);
    rd_both("last_wins_x12", 5'd12, 32'h2);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
